// File: rtl/snake_body_buffer_if.sv
// rtl/snake_body_buffer_if.sv - control, step and render-query signals of the snake body store
interface snake_body_buffer_if #(
    parameter int COORD_BITS = 7,
    parameter int LEN_BITS   = 6
);
    logic                  init;
    logic                  game_tik;
    logic [1:0]            dir;
    logic                  grow;
    logic [COORD_BITS-1:0] query_x;
    logic [COORD_BITS-1:0] query_y;
    logic [COORD_BITS-1:0] snake_head_x;
    logic [COORD_BITS-1:0] snake_head_y;
    logic [LEN_BITS-1:0]   snake_length;
    logic [1:0]            cell_type;
    logic                  busy;
    logic                  step_done;
    logic                  collision_detected;

    modport master (
        output init, game_tik, dir, grow, query_x, query_y,
        input  snake_head_x, snake_head_y, snake_length, cell_type,
               busy, step_done, collision_detected
    );

    modport slave (
        input  init, game_tik, dir, grow, query_x, query_y,
        output snake_head_x, snake_head_y, snake_length, cell_type,
               busy, step_done, collision_detected
    );
endinterface

// File: rtl/snake_body_buffer.sv
// rtl/snake_body_buffer.sv - snake segment store with stepping, growth, self-collision scan and cell query
module snake_body_buffer #(
    parameter int COORD_BITS = 7,
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 60,
    parameter int MAX_LEN    = 32,
    parameter int LEN_BITS   = 6,
    parameter int INIT_LEN   = 3,
    parameter int WRAP       = 0,
    parameter int START_X    = 20,
    parameter int START_Y    = 15
) (
    input logic                clock_25,
    input logic                reset,
    snake_body_buffer_if.slave bus
);
    localparam int IDX_BITS = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [COORD_BITS-1:0] X_MAX   = COORD_BITS'(GRID_W - 1);
    localparam logic [COORD_BITS-1:0] Y_MAX   = COORD_BITS'(GRID_H - 1);
    localparam logic [COORD_BITS-1:0] C_ONE   = COORD_BITS'(1);
    localparam logic [LEN_BITS-1:0]   L_ONE   = LEN_BITS'(1);
    localparam logic [LEN_BITS-1:0]   L_INIT  = LEN_BITS'(INIT_LEN);
    localparam logic [LEN_BITS-1:0]   L_MAX   = LEN_BITS'(MAX_LEN);
    localparam logic [COORD_BITS-1:0] START_YC = COORD_BITS'(START_Y);

    typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [COORD_BITS-1:0] r_seg_x [MAX_LEN];
    logic [COORD_BITS-1:0] r_seg_y [MAX_LEN];
    logic [LEN_BITS-1:0]   r_len, r_idx;
    logic [1:0]            r_dir, w_dir, r_cell, w_cell;
    logic                  r_coll, r_step_done;
    logic [COORD_BITS-1:0] w_nx, w_ny;
    logic                  w_wall, w_take, w_move, w_scan_last, w_hit, w_body;

    // Tail slots beyond INIT_LEN all collapse onto the last initial segment.
    function automatic logic [COORD_BITS-1:0] start_x(input int i);
        return (i < INIT_LEN) ? COORD_BITS'(START_X - i) : COORD_BITS'(START_X - INIT_LEN + 1);
    endfunction

    always_comb begin
        w_dir  = (bus.dir == {r_dir[1], ~r_dir[0]}) ? r_dir : bus.dir;
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_wall = 1'b0;
        case (w_dir)
            2'b00: if (r_seg_x[0] == X_MAX) begin w_nx = '0;    w_wall = (WRAP == 0); end
                   else w_nx = r_seg_x[0] + C_ONE;
            2'b01: if (r_seg_x[0] == '0)    begin w_nx = X_MAX; w_wall = (WRAP == 0); end
                   else w_nx = r_seg_x[0] - C_ONE;
            2'b10: if (r_seg_y[0] == '0)    begin w_ny = Y_MAX; w_wall = (WRAP == 0); end
                   else w_ny = r_seg_y[0] - C_ONE;
            default: if (r_seg_y[0] == Y_MAX) begin w_ny = '0;  w_wall = (WRAP == 0); end
                   else w_ny = r_seg_y[0] + C_ONE;
        endcase
    end

    assign w_take      = bus.game_tik && (r_state == S_IDLE) && !r_coll && !bus.init;
    assign w_move      = w_take && !w_wall;
    assign w_scan_last = (r_idx == r_len - L_ONE);
    assign w_hit       = (r_seg_x[r_idx[IDX_BITS-1:0]] == r_seg_x[0]) &&
                         (r_seg_y[r_idx[IDX_BITS-1:0]] == r_seg_y[0]);

    always_comb begin
        w_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (i < int'(r_len) && r_seg_x[i] == bus.query_x && r_seg_y[i] == bus.query_y)
                w_body = 1'b1;
        end
        if (r_seg_x[0] == bus.query_x && r_seg_y[0] == bus.query_y) w_cell = 2'b10;
        else if (w_body)                                             w_cell = 2'b01;
        else                                                         w_cell = 2'b00;
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.init) w_state_nxt = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:  if (w_move)      w_state_nxt = S_SCAN;
                default: if (w_scan_last) w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy = (r_state == S_SCAN);
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= start_x(i);
                r_seg_y[i] <= START_YC;
            end
            r_len <= L_INIT; r_idx <= L_ONE; r_dir <= 2'b00;
            r_coll <= 1'b0; r_step_done <= 1'b0; r_cell <= 2'b00;
        end else if (bus.init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= start_x(i);
                r_seg_y[i] <= START_YC;
            end
            r_len <= L_INIT; r_idx <= L_ONE; r_dir <= 2'b00;
            r_coll <= 1'b0; r_step_done <= 1'b0; r_cell <= 2'b00;
        end else begin
            r_step_done <= 1'b0;
            r_cell      <= w_cell;
            if (w_take && w_wall) begin
                r_coll      <= 1'b1;
                r_step_done <= 1'b1;
            end
            if (w_move) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                r_seg_x[0] <= w_nx;
                r_seg_y[0] <= w_ny;
                r_dir      <= w_dir;
                r_idx      <= L_ONE;
                if (bus.grow && r_len < L_MAX) r_len <= r_len + L_ONE;
            end
            // The scan always walks the full body so step latency is fixed at the length.
            if (r_state == S_SCAN) begin
                if (w_hit) r_coll <= 1'b1;
                if (w_scan_last) r_step_done <= 1'b1;
                else             r_idx <= r_idx + L_ONE;
            end
        end
    end

    assign bus.snake_head_x       = r_seg_x[0];
    assign bus.snake_head_y       = r_seg_y[0];
    assign bus.snake_length       = r_len;
    assign bus.cell_type          = r_cell;
    assign bus.step_done          = r_step_done;
    assign bus.collision_detected = r_coll;
endmodule
